// File: rtl/fsa_scan_sequencer_if.sv
// Analyzer-side bus of the fsa scan sequencer: aligned pixel strobe, positional flags, column index
// and the analyzer's result-latched pulse flowing back.
interface fsa_scan_sequencer_if #(
  parameter int C_IMG_WW = 12
);
  logic                wr_sof_d3;
  logic                rd_en_d3;
  logic                hfirst_p3;
  logic                hM3_p3;
  logic                hM2_p3;
  logic                hlast_p3;
  logic                wfirst_p3;
  logic                wlast_p3;
  logic [C_IMG_WW-1:0] x_d3;
  logic                ana_done;

  modport master (
    output wr_sof_d3, rd_en_d3, hfirst_p3, hM3_p3, hM2_p3, hlast_p3, wfirst_p3, wlast_p3, x_d3,
    input  ana_done
  );

  modport slave (
    input  wr_sof_d3, rd_en_d3, hfirst_p3, hM3_p3, hM2_p3, hlast_p3, wfirst_p3, wlast_p3, x_d3,
    output ana_done
  );
endinterface

// File: rtl/fsa_scan_sequencer.sv
// Frame-scan controller for the fsa analyzer: row/column sequencing, 3-stage aligned flags, result handshake.
// Optional FSA_SCAN_PERF_EN adds frame/stall cycle counters.
module fsa_scan_sequencer #(
  parameter int C_IMG_HW   = 12,
  parameter int C_IMG_WW   = 12,
  parameter int C_LINE_GAP = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [C_IMG_WW-1:0] cfg_width,
  input  logic [C_IMG_HW-1:0] cfg_height,
  input  logic                sof,
  input  logic                rd_ready,
  output logic                busy,
  output logic                cfg_err,
  output logic                overrun,
  input  logic                res_ack,
  output logic                res_pending,
  output logic                res_lost,
  input  logic                err_clr,
`ifdef FSA_SCAN_PERF_EN
  output logic [31:0]         perf_frame_cycles,
  output logic [31:0]         perf_stall_cycles,
`endif
  fsa_scan_sequencer_if.master ana
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_RDY, ST_LINE, ST_GAP} state_t;

  localparam int               PW       = 8 + C_IMG_WW;
  localparam logic [3:0]       GAP_LAST = 4'(C_LINE_GAP - 1);
  localparam logic [C_IMG_WW-1:0] W_ONE = 1;
  localparam logic [C_IMG_WW-1:0] W_TWO = 2;
  localparam logic [C_IMG_HW-1:0] H_ONE = 1;
  localparam logic [C_IMG_HW-1:0] H_TWO = 2;
  localparam logic [C_IMG_HW-1:0] H_THR = 3;
  localparam logic [C_IMG_HW-1:0] H_FOU = 4;

  state_t              state_reg;
  logic [C_IMG_WW-1:0] w_reg, x_reg;
  logic [C_IMG_HW-1:0] h_reg, y_reg;
  logic [3:0]          gap_reg;
  logic                last_row_reg;
  logic                cfg_err_reg, overrun_reg, res_pending_reg, res_lost_reg;
  logic [PW-1:0]       pipe_reg [1:3];

  logic          cfg_ok, x_last, y_last, rd_en_raw, accept_sof;
  logic [PW-1:0] stage0;

  assign cfg_ok     = (cfg_width >= W_TWO) && (cfg_height >= H_FOU);
  assign accept_sof = (state_reg == ST_IDLE) && sof && cfg_ok;
  assign x_last     = (x_reg == w_reg - W_ONE);
  assign y_last     = (y_reg == h_reg - H_ONE);
  assign rd_en_raw  = (state_reg == ST_LINE);

  // hfirst is held through the pre-row-0 wait so the analyzer's per-frame clear always fires
  always_comb begin
    stage0 = '0;
    stage0[PW-1] = sof;
    stage0[PW-2] = rd_en_raw;
    stage0[PW-3] = accept_sof ||
                   (((state_reg == ST_WAIT_RDY) || rd_en_raw) && (y_reg == '0));
    stage0[PW-4] = rd_en_raw && (y_reg == h_reg - H_THR);
    stage0[PW-5] = rd_en_raw && (y_reg == h_reg - H_TWO);
    stage0[PW-6] = rd_en_raw && y_last;
    stage0[PW-7] = rd_en_raw && (x_reg == '0);
    stage0[PW-8] = rd_en_raw && x_last;
    stage0[C_IMG_WW-1:0] = rd_en_raw ? x_reg : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 1; i <= 3; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[1] <= stage0;
      for (int i = 2; i <= 3; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign ana.wr_sof_d3 = pipe_reg[3][PW-1];
  assign ana.rd_en_d3  = pipe_reg[3][PW-2];
  assign ana.hfirst_p3 = pipe_reg[3][PW-3];
  assign ana.hM3_p3    = pipe_reg[3][PW-4];
  assign ana.hM2_p3    = pipe_reg[3][PW-5];
  assign ana.hlast_p3  = pipe_reg[3][PW-6];
  assign ana.wfirst_p3 = pipe_reg[3][PW-7];
  assign ana.wlast_p3  = pipe_reg[3][PW-8];
  assign ana.x_d3      = pipe_reg[3][C_IMG_WW-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      w_reg           <= '0;
      h_reg           <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      gap_reg         <= '0;
      last_row_reg    <= 1'b0;
      cfg_err_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
      res_pending_reg <= 1'b0;
      res_lost_reg    <= 1'b0;
    end else begin
      cfg_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (sof) begin
            w_reg <= cfg_width;
            h_reg <= cfg_height;
            if (cfg_ok) begin
              y_reg     <= '0;
              state_reg <= ST_WAIT_RDY;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end
        end
        ST_WAIT_RDY: begin
          if (rd_ready) begin
            x_reg     <= '0;
            state_reg <= ST_LINE;
          end
        end
        ST_LINE: begin
          x_reg <= x_reg + W_ONE;
          if (x_last) begin
            y_reg        <= y_reg + H_ONE;
            last_row_reg <= y_last;
            gap_reg      <= '0;
            if (C_LINE_GAP == 0) state_reg <= y_last ? ST_IDLE : ST_WAIT_RDY;
            else                 state_reg <= ST_GAP;
          end
        end
        ST_GAP: begin
          gap_reg <= gap_reg + 4'd1;
          if (gap_reg == GAP_LAST) state_reg <= last_row_reg ? ST_IDLE : ST_WAIT_RDY;
        end
        default: state_reg <= ST_IDLE;
      endcase

      // error events take priority over a coincident clear
      if (sof && (state_reg != ST_IDLE)) overrun_reg <= 1'b1;
      else if (err_clr)                  overrun_reg <= 1'b0;

      if (ana.ana_done)     res_pending_reg <= 1'b1;
      else if (res_ack)     res_pending_reg <= 1'b0;

      if (ana.ana_done && res_pending_reg && !res_ack) res_lost_reg <= 1'b1;
      else if (err_clr)                                res_lost_reg <= 1'b0;
    end
  end

  assign busy        = (state_reg != ST_IDLE);
  assign cfg_err     = cfg_err_reg;
  assign overrun     = overrun_reg;
  assign res_pending = res_pending_reg;
  assign res_lost    = res_lost_reg;

`ifdef FSA_SCAN_PERF_EN
  logic [31:0] frame_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else if (accept_sof) begin
      frame_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else if (state_reg != ST_IDLE) begin
      if (frame_cnt_reg != '1) frame_cnt_reg <= frame_cnt_reg + 32'd1;
      if ((state_reg == ST_WAIT_RDY) && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_frame_cycles = frame_cnt_reg;
  assign perf_stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: doc/fsa_scan_sequencer.md
Name: fsa_scan_sequencer

Overview:
Frame-scan controller for the fsa edge/header/corner analyzer. On each frame start it latches the image geometry and waits for line-buffer readiness per row. It then generates the row/column read sequence and positional flags, delayed through a 3-stage pipeline so they arrive aligned with the analyzer's _d3/_p3 inputs. It also owns the result handshake toward software: it holds the analyzer's ana_done pulse as a pending result until acknowledged.

Parameters:
C_IMG_HW, 12, height/row-index width
C_IMG_WW, 12, width/column-index width
C_LINE_GAP, 2, idle cycles inserted after each row (0..15)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
cfg_width  in  C_IMG_WW  pixels per row, sampled at sof
cfg_height  in  C_IMG_HW  rows per frame, sampled at sof
sof  in  1  frame-start pulse from frame writer
rd_ready  in  1  line buffer holds next row; sampled in WAIT_RDY
wr_sof_d3  out  1  sof delayed 3 cycles
rd_en_d3  out  1  pixel-valid strobe
hfirst_p3  out  1  row 0
hM3_p3  out  1  row H-3
hM2_p3  out  1  row H-2
hlast_p3  out  1  row H-1
wfirst_p3  out  1  column 0
wlast_p3  out  1  column W-1
x_d3  out  C_IMG_WW  column index
busy  out  1  frame scan in progress
cfg_err  out  1  one-cycle pulse: geometry rejected
overrun  out  1  sticky: sof received while busy
ana_done  in  1  analyzer result-latched pulse
res_ack  in  1  software acknowledge
res_pending  out  1  result available (interrupt level)
res_lost  out  1  sticky: ana_done while res_pending
err_clr  in  1  clears overrun and res_lost

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all pipeline stages cleared. Reset mid-frame aborts the scan immediately, and no partial rd_en is emitted afterwards.
- Stage 0 (raw) signals are computed from the FSM and counters. The three register stages that follow produce every *_d3/*_p3 output, all with identical 3-cycle latency. wr_sof_d3 passes through the same stages.
- FSM states: IDLE, WAIT_RDY, LINE, GAP.
- IDLE + sof:
  - Latch W = cfg_width and H = cfg_height.
  - If W < 2 or H < 4, pulse cfg_err in the next cycle, stay IDLE, and emit no rd_en. wr_sof is still propagated.
  - Otherwise y = 0 and go to WAIT_RDY.
- WAIT_RDY: on rd_ready = 1, x = 0 and go to LINE.
- LINE:
  - rd_en_raw = 1 every cycle; x increments by 1.
  - When x == W-1, go to GAP, or to WAIT_RDY if C_LINE_GAP == 0.
  - y increments at the end of the row.
- GAP: count C_LINE_GAP cycles, then go to WAIT_RDY. If the finished row was H-1, go to IDLE instead.
- Flags at stage 0 are combinational on y/x vs latched H/W: hfirst = (y==0), hM3 = (y==H-3), hM2 = (y==H-2), hlast = (y==H-1), wfirst = (x==0), wlast = (x==W-1).
- Flags are valid only while rd_en_raw = 1; otherwise they are driven 0. The exception is hfirst, which stays asserted from sof until the first pixel of row 0 so the analyzer's per-frame edge clear fires.
- Comparisons use C_IMG_HW/C_IMG_WW-bit unsigned arithmetic; H-3 cannot underflow because H ≥ 4.
- busy = FSM != IDLE; it falls in the cycle after the last GAP cycle.
- sof while busy: ignored for scanning, overrun set, wr_sof_d3 still propagated. The analyzer captures the previous frame's results on wr_sof.
- Result handshake:
  - ana_done sets res_pending.
  - res_ack clears it.
  - Simultaneous ana_done and res_ack: pending stays 1 (new result wins).
  - ana_done while pending and no ack sets res_lost.
- err_clr clears the sticky bits in the next cycle. An error event in the same cycle as err_clr wins.

Optional Feature:
FSA_SCAN_PERF_EN
- Defined: adds outputs perf_frame_cycles [31:0] and perf_stall_cycles [31:0].
  - Both counters clear on an accepted sof.
  - perf_frame_cycles counts every cycle while busy.
  - perf_stall_cycles counts cycles spent in WAIT_RDY.
  - Both hold their value in IDLE and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- W=8, H=4, gap=2, rd_ready tied 1, sof at cycle 0:
  - 32 rd_en_d3 pulses, first at cycle 5 (1 cycle to WAIT_RDY, 1 to LINE, +3 pipeline).
  - x_d3 runs 0..7 per row; wlast on x=7.
  - hfirst on row 0, hM3 on row 1, hM2 on row 2, hlast on row 3.
  - busy deasserts after row 3 GAP.
- W=8, H=6, rd_ready low for 5 cycles before row 2: row 2 pulses start exactly 5 cycles late, no pulses are lost, and perf_stall_cycles (if enabled) is ≥ 5 for that frame.
- sof with W=1 or H=3: cfg_err pulses once, no rd_en, wr_sof_d3 still pulses 3 cycles after sof.
- Second sof during scan of W=16, H=8: overrun = 1, the scan completes unchanged with 128 pulses, wr_sof_d3 pulses; err_clr then drops overrun to 0.
- ana_done, then no ack, then ana_done again: res_pending = 1 and res_lost = 1. res_ack alone clears res_pending; ack coincident with ana_done keeps it at 1.
- resetn low mid-row for 1 cycle: all outputs 0 next cycle, FSM in IDLE, no rd_en_d3 afterwards until a new sof.
